// File: rtl/ctrl_pkt_pkg.sv
// rtl/ctrl_pkt_pkg.sv - shared header layout, magic value and state encoding for ctrl_pkt_gen
//
// Purpose: single source for the control-packet header bit positions and the
// transmitter state encoding, so the generator and anything decoding its
// output agree on the same layout.
// Ports: none (package).

package ctrl_pkt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_PAY0 = 3'd2,
    ST_PAY1 = 3'd3,
    ST_GAP  = 3'd4
  } pkt_state_t;

  localparam logic [15:0] HDR_MAGIC = 16'hF1F2;

  // Header beat tdata field offsets (LSB positions)
  localparam int HDR_MAGIC_LSB = 0;
  localparam int HDR_STAGE_LSB = 104;
  localparam int HDR_RES_LSB   = 112;
  localparam int HDR_IDX_LSB   = 120;
  localparam int HDR_SEQ_LSB   = 128;

  // Header beat tuser field: packet length in bytes
  localparam int HDR_LEN_LSB   = 0;

  // Only two payload beats exist in the request, so a beat count of 3 means 2.
  function automatic logic [1:0] clamp_beats(input logic [1:0] beats);
    return (beats == 2'd3) ? 2'd2 : beats;
  endfunction

endpackage

// File: rtl/ctrl_pkt_gen.sv
// rtl/ctrl_pkt_gen.sv - control-bus packet transmitter for the stage control chain
//
// Purpose: accepts one table-write request at a time and emits it as a
// header beat followed by 0..2 payload beats on consecutive cycles, then
// holds off for IFG_CYCLES idle cycles. The output stream has no tready,
// so once a request is accepted the packet is sent without gaps.
//
// Ports:
//   axis_clk          - clock
//   areset            - synchronous active-high reset
//   req_valid/ready   - request handshake (ready only in IDLE, out of reset)
//   req_stage_id      - target stage ID (5b)
//   req_resource_id   - target table/resource inside the stage (8b)
//   req_index         - entry index (8b)
//   req_beats         - payload beat count (3 is treated as 2)
//   req_data          - payload, beat 0 in the low half
//   c_m_axis_*        - control stream (tdata/tuser/tkeep/tvalid/tlast)
//   pkt_sent_cnt      - completed packet count, wraps modulo 2^32
//
// C_S_AXIS_DATA_WIDTH must be at least 144 (header reaches bit 143) and
// C_S_AXIS_TUSER_WIDTH at least 16.

module ctrl_pkt_gen
  import ctrl_pkt_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int IFG_CYCLES           = 2
) (
  input  logic                                axis_clk,
  input  logic                                areset,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic [4:0]                          req_stage_id,
  input  logic [7:0]                          req_resource_id,
  input  logic [7:0]                          req_index,
  input  logic [1:0]                          req_beats,
  input  logic [2*C_S_AXIS_DATA_WIDTH-1:0]    req_data,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]      c_m_axis_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]     c_m_axis_tuser,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]    c_m_axis_tkeep,
  output logic                                c_m_axis_tvalid,
  output logic                                c_m_axis_tlast,
  output logic [31:0]                         pkt_sent_cnt
);

  localparam int DW         = C_S_AXIS_DATA_WIDTH;
  localparam int BEAT_BYTES = DW / 8;
  localparam int GAP_W      = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  // Gap counter counts down to zero, so it is loaded with IFG_CYCLES-1.
  localparam logic [GAP_W-1:0] GAP_LOAD = (IFG_CYCLES > 0) ? GAP_W'(IFG_CYCLES - 1) : '0;
  // With no inter-frame gap the block is ready again right after the last beat.
  localparam pkt_state_t AFTER_LAST = (IFG_CYCLES > 0) ? ST_GAP : ST_IDLE;

  pkt_state_t            r_state;
  pkt_state_t            w_next_state;

  logic [4:0]            r_stage_id;
  logic [7:0]            r_resource_id;
  logic [7:0]            r_index;
  logic [1:0]            r_beats;
  logic [2*DW-1:0]       r_data;
  logic [15:0]           r_seq;
  logic [31:0]           r_pkt_cnt;
  logic [GAP_W-1:0]      r_gap_cnt;

  logic                  w_accept;
  logic                  w_last_beat;
  logic [15:0]           w_hdr_len;

  // Ready is gated by areset so nothing is accepted while reset is held.
  assign req_ready   = (r_state == ST_IDLE) && !areset;
  assign w_accept    = req_valid && req_ready;

  assign w_last_beat = ((r_state == ST_HDR)  && (r_beats == 2'd0)) ||
                       ((r_state == ST_PAY0) && (r_beats == 2'd1)) ||
                        (r_state == ST_PAY1);

  assign w_hdr_len   = 16'((32'(r_beats) + 32'd1) * 32'(BEAT_BYTES));

  assign pkt_sent_cnt = r_pkt_cnt;

  // State register
  always_ff @(posedge axis_clk) begin
    if (areset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next_state = ST_HDR;
      ST_HDR:  w_next_state = (r_beats != 2'd0) ? ST_PAY0 : AFTER_LAST;
      ST_PAY0: w_next_state = (r_beats == 2'd2) ? ST_PAY1 : AFTER_LAST;
      ST_PAY1: w_next_state = AFTER_LAST;
      ST_GAP:  if (r_gap_cnt == '0) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Request capture, sequence/packet counters and gap timer
  always_ff @(posedge axis_clk) begin
    if (areset) begin
      r_stage_id    <= '0;
      r_resource_id <= '0;
      r_index       <= '0;
      r_beats       <= '0;
      r_seq         <= '0;
      r_pkt_cnt     <= '0;
      r_gap_cnt     <= '0;
    end else begin
      if (w_accept) begin
        r_stage_id    <= req_stage_id;
        r_resource_id <= req_resource_id;
        r_index       <= req_index;
        r_beats       <= clamp_beats(req_beats);
      end
      // Counters only move on a completed packet; an abandoned one never gets here.
      if (w_last_beat) begin
        r_seq     <= r_seq + 16'd1;
        r_pkt_cnt <= r_pkt_cnt + 32'd1;
      end
      if (w_last_beat) begin
        r_gap_cnt <= GAP_LOAD;
      end else if ((r_state == ST_GAP) && (r_gap_cnt != '0)) begin
        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
      end
    end
  end

  // Payload is wide and fully qualified by state, so it needs no reset.
  always_ff @(posedge axis_clk) begin
    if (w_accept) begin
      r_data <= req_data;
    end
  end

  // Output logic: everything is zero outside the beat-carrying states.
  always_comb begin
    c_m_axis_tdata  = '0;
    c_m_axis_tuser  = '0;
    c_m_axis_tkeep  = '0;
    c_m_axis_tvalid = 1'b0;
    case (r_state)
      ST_HDR: begin
        c_m_axis_tdata[HDR_MAGIC_LSB +: 16] = HDR_MAGIC;
        c_m_axis_tdata[HDR_STAGE_LSB +: 5]  = r_stage_id;
        c_m_axis_tdata[HDR_RES_LSB   +: 8]  = r_resource_id;
        c_m_axis_tdata[HDR_IDX_LSB   +: 8]  = r_index;
        c_m_axis_tdata[HDR_SEQ_LSB   +: 16] = r_seq;
        c_m_axis_tuser[HDR_LEN_LSB   +: 16] = w_hdr_len;
        c_m_axis_tkeep  = '1;
        c_m_axis_tvalid = 1'b1;
      end
      ST_PAY0: begin
        c_m_axis_tdata  = r_data[DW-1:0];
        c_m_axis_tkeep  = '1;
        c_m_axis_tvalid = 1'b1;
      end
      ST_PAY1: begin
        c_m_axis_tdata  = r_data[2*DW-1:DW];
        c_m_axis_tkeep  = '1;
        c_m_axis_tvalid = 1'b1;
      end
      default: begin
      end
    endcase
    c_m_axis_tlast = w_last_beat;
  end

endmodule

// File: tb/tb_ctrl_pkt_gen.sv
// tb/tb_ctrl_pkt_gen.sv - self-checking bench for ctrl_pkt_gen

module tb_ctrl_pkt_gen;

  localparam int DW  = 256;
  localparam int UW  = 128;
  localparam int KW  = DW / 8;
  localparam int IFG = 2;

  logic axis_clk = 1'b0;
  always #5 axis_clk = ~axis_clk;

  // Main instance (default parameters)
  logic            areset, req_valid, req_ready;
  logic [4:0]      req_stage_id;
  logic [7:0]      req_resource_id, req_index;
  logic [1:0]      req_beats;
  logic [2*DW-1:0] req_data;
  logic [DW-1:0]   tdata;
  logic [UW-1:0]   tuser;
  logic [KW-1:0]   tkeep;
  logic            tvalid, tlast;
  logic [31:0]     pkt_cnt;

  // Second instance with no inter-frame gap, used for the sequence wrap run
  logic            z_areset, z_valid, z_ready;
  logic [4:0]      z_stage;
  logic [7:0]      z_res, z_idx;
  logic [1:0]      z_beats;
  logic [2*DW-1:0] z_data;
  logic [DW-1:0]   z_tdata;
  logic [UW-1:0]   z_tuser;
  logic [KW-1:0]   z_tkeep;
  logic            z_tvalid, z_tlast;
  logic [31:0]     z_cnt;

  ctrl_pkt_gen #(.C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW), .IFG_CYCLES(IFG)) dut (
    .axis_clk(axis_clk), .areset(areset), .req_valid(req_valid), .req_ready(req_ready),
    .req_stage_id(req_stage_id), .req_resource_id(req_resource_id), .req_index(req_index),
    .req_beats(req_beats), .req_data(req_data),
    .c_m_axis_tdata(tdata), .c_m_axis_tuser(tuser), .c_m_axis_tkeep(tkeep),
    .c_m_axis_tvalid(tvalid), .c_m_axis_tlast(tlast), .pkt_sent_cnt(pkt_cnt)
  );

  ctrl_pkt_gen #(.C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW), .IFG_CYCLES(0)) dut_z (
    .axis_clk(axis_clk), .areset(z_areset), .req_valid(z_valid), .req_ready(z_ready),
    .req_stage_id(z_stage), .req_resource_id(z_res), .req_index(z_idx),
    .req_beats(z_beats), .req_data(z_data),
    .c_m_axis_tdata(z_tdata), .c_m_axis_tuser(z_tuser), .c_m_axis_tkeep(z_tkeep),
    .c_m_axis_tvalid(z_tvalid), .c_m_axis_tlast(z_tlast), .pkt_sent_cnt(z_cnt)
  );

  int n_checks;
  int n_fail;

  typedef struct {
    int            cyc;
    logic [DW-1:0] d;
    logic [UW-1:0] u;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  beat_t mon_q[$];
  beat_t exp_q[$];
  int    cyc = 0;
  int    idle_bad = 0;

  logic [15:0] m_seq;
  logic [31:0] m_cnt;

  always @(posedge axis_clk) cyc <= cyc + 1;

  // Beat monitor for the main instance; idle cycles must be all-zero.
  always @(negedge axis_clk) begin : mon
    beat_t b;
    if (tvalid) begin
      b.cyc = cyc; b.d = tdata; b.u = tuser; b.k = tkeep; b.l = tlast;
      mon_q.push_back(b);
    end else if (tdata != '0 || tuser != '0 || tkeep != '0 || tlast) begin
      idle_bad++;
    end
  end

  // Monitor for the no-gap instance: header-only packets, one every 2 cycles
  int          z_n = 0, z_last = 0, z_bad = 0;
  logic [15:0] z_s1 = '0, z_s2 = '0;
  always @(negedge axis_clk) begin
    if (z_tvalid) begin
      z_n = z_n + 1;
      if (z_n > 1 && (cyc - z_last) != 2) z_bad++;
      if (!z_tlast || z_tuser[15:0] != 16'd32) z_bad++;
      z_last = cyc;
      if (z_n == 65536) z_s1 = z_tdata[143:128];
      if (z_n == 65537) z_s2 = z_tdata[143:128];
    end
  end

  // Reference model: expected beats with cycle offsets from the header.
  task automatic model_pkt(input logic [4:0] st, input logic [7:0] rs, input logic [7:0] ix,
                           input logic [1:0] bt, input logic [2*DW-1:0] dat);
    int    n;
    beat_t b;
    n = (bt > 2'd2) ? 2 : int'(bt);
    exp_q.delete();
    b.cyc = 0;
    b.d = '0;
    b.d[15:0]    = 16'hF1F2;
    b.d[108:104] = st;
    b.d[119:112] = rs;
    b.d[127:120] = ix;
    b.d[143:128] = m_seq;
    b.u = '0;
    b.u[15:0] = 16'((1 + n) * (DW / 8));
    b.k = '1;
    b.l = (n == 0);
    exp_q.push_back(b);
    for (int i = 0; i < n; i++) begin
      b.cyc = i + 1;
      b.d = dat[i*DW +: DW];
      b.u = '0;
      b.l = (i == n - 1);
      exp_q.push_back(b);
    end
    m_seq = m_seq + 16'd1;
    m_cnt = m_cnt + 32'd1;
  endtask

  function automatic logic [2*DW-1:0] rand_data();
    logic [2*DW-1:0] d;
    for (int i = 0; i < 2*DW/32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Called at posedge+1. Returns the cycle the header shows (acc) and the
  // number of sampled cycles with req_ready low before acceptance.
  task automatic send_req(input logic [4:0] st, input logic [7:0] rs, input logic [7:0] ix,
                          input logic [1:0] bt, input logic [2*DW-1:0] dat, input bit hold,
                          output int acc, output int waits);
    bit r;
    bit ok;
    req_valid = 1'b1; req_stage_id = st; req_resource_id = rs; req_index = ix;
    req_beats = bt; req_data = dat;
    acc = -1; waits = 0; ok = 1'b0;
    for (int t = 0; t < 64 && !ok; t++) begin
      @(negedge axis_clk);
      r = req_ready;
      @(posedge axis_clk);
      #1;
      if (r) begin ok = 1'b1; acc = cyc; end
      else waits++;
    end
    if (!hold) begin
      req_valid = 1'b0;
      req_stage_id = 5'($urandom); req_resource_id = 8'($urandom);
      req_index = 8'($urandom); req_beats = 2'($urandom); req_data = rand_data();
    end
  endtask

  task automatic collect(input int bound, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < bound && !ok; t++) begin
      @(posedge axis_clk);
      #1;
      foreach (mon_q[i]) if (mon_q[i].l) ok = 1'b1;
    end
  endtask

  task automatic do_reset();
    areset = 1'b1;
    repeat (2) begin @(posedge axis_clk); #1; end
    areset = 1'b0;
    mon_q.delete();
    m_seq = '0; m_cnt = '0;
  endtask

  task automatic test_reset();
    areset = 1'b1; z_areset = 1'b1;
    repeat (3) @(posedge axis_clk);
    #1;
    @(negedge axis_clk);
    n_checks++;
    if (tvalid !== 1'b0 || tlast !== 1'b0 || tdata !== '0 || tuser !== '0 || tkeep !== '0) begin
      n_fail++; $display("FAIL reset_outputs: tvalid=%0b tlast=%0b tkeep=%0h, required all zero", tvalid, tlast, tkeep);
    end
    n_checks++;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %0b required 0", req_ready); end
    n_checks++;
    if (pkt_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d required 0", pkt_cnt); end
    @(posedge axis_clk); #1;
    areset = 1'b0; z_areset = 1'b0;
    @(negedge axis_clk);
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %0b required 1", req_ready); end
    n_checks++;
    if (z_ready !== 1'b1) begin n_fail++; $display("FAIL z_ready_after_reset: got %0b required 1", z_ready); end
    @(posedge axis_clk); #1;
    mon_q.delete();
    m_seq = '0; m_cnt = '0;
  endtask

  task automatic test_basic();
    logic [2*DW-1:0] dat;
    int acc, waits;
    bit ok;
    dat = rand_data();
    mon_q.delete();
    model_pkt(5'd3, 8'd1, 8'd5, 2'd2, dat);
    send_req(5'd3, 8'd1, 8'd5, 2'd2, dat, 1'b0, acc, waits);
    collect(20, ok);
    n_checks++;
    if (!ok || mon_q.size() != 3) begin
      n_fail++; $display("FAIL basic_beats: got %0d beats (done=%0b) required 3", mon_q.size(), ok);
    end else begin
      n_checks++;
      if (mon_q[0].cyc != acc) begin n_fail++; $display("FAIL basic_latency: header at %0d required %0d", mon_q[0].cyc, acc); end
      n_checks++;
      if (mon_q[0].u[15:0] !== 16'd96 || mon_q[0].u[UW-1:16] !== '0) begin
        n_fail++; $display("FAIL basic_tuser: got %0h required 96 decimal in [15:0]", mon_q[0].u);
      end
      n_checks++;
      if (mon_q[0].d !== exp_q[0].d || mon_q[0].d[143:128] !== 16'h0000) begin
        n_fail++; $display("FAIL basic_header: got %h required %h", mon_q[0].d, exp_q[0].d);
      end
      n_checks++;
      if (mon_q[1].d !== dat[DW-1:0] || mon_q[2].d !== dat[2*DW-1:DW]) begin
        n_fail++; $display("FAIL basic_payload: beat1 %h beat2 %h", mon_q[1].d, mon_q[2].d);
      end
      n_checks++;
      if (mon_q[0].l || mon_q[1].l || !mon_q[2].l || mon_q[1].u !== '0 || mon_q[2].k !== '1) begin
        n_fail++; $display("FAIL basic_tlast: got %0b%0b%0b required 001", mon_q[0].l, mon_q[1].l, mon_q[2].l);
      end
    end
    for (int g = 0; g < IFG; g++) begin
      @(negedge axis_clk);
      n_checks++;
      if (tvalid !== 1'b0 || req_ready !== 1'b0) begin
        n_fail++; $display("FAIL basic_gap%0d: tvalid=%0b ready=%0b required 0 0", g, tvalid, req_ready);
      end
    end
    @(negedge axis_clk);
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_after_gap: got %0b required 1", req_ready); end
    @(posedge axis_clk); #1;
  endtask

  task automatic test_header_only();
    logic [2*DW-1:0] dat;
    int acc, waits;
    bit ok;
    do_reset();
    dat = rand_data();
    model_pkt(5'd17, 8'hA5, 8'h3C, 2'd0, dat);
    send_req(5'd17, 8'hA5, 8'h3C, 2'd0, dat, 1'b0, acc, waits);
    collect(20, ok);
    n_checks++;
    if (!ok || mon_q.size() != 1) begin
      n_fail++; $display("FAIL hdr_only_beats: got %0d beats required 1", mon_q.size());
    end else begin
      n_checks++;
      if (mon_q[0].l !== 1'b1 || mon_q[0].u[15:0] !== 16'd32 || mon_q[0].cyc != acc) begin
        n_fail++; $display("FAIL hdr_only_beat: tlast=%0b len=%0d cyc=%0d required 1 32 %0d", mon_q[0].l, mon_q[0].u[15:0], mon_q[0].cyc, acc);
      end
      n_checks++;
      if (mon_q[0].d !== exp_q[0].d) begin n_fail++; $display("FAIL hdr_only_data: got %h required %h", mon_q[0].d, exp_q[0].d); end
    end
    n_checks++;
    if (pkt_cnt !== m_cnt) begin n_fail++; $display("FAIL hdr_only_cnt: got %0d required %0d", pkt_cnt, m_cnt); end
  endtask

  task automatic test_clamp();
    logic [2*DW-1:0] dat;
    logic [4:0] st;
    logic [7:0] rs, ix;
    int acc, waits;
    bit ok;
    dat = rand_data(); st = 5'($urandom); rs = 8'($urandom); ix = 8'($urandom);
    mon_q.delete();
    model_pkt(st, rs, ix, 2'd3, dat);
    send_req(st, rs, ix, 2'd3, dat, 1'b0, acc, waits);
    collect(20, ok);
    n_checks++;
    if (!ok || mon_q.size() != 3) begin
      n_fail++; $display("FAIL clamp_beats: got %0d beats required 3", mon_q.size());
    end else begin
      n_checks++;
      if (mon_q[0].u[15:0] !== 16'd96 || mon_q[0].d !== exp_q[0].d) begin
        n_fail++; $display("FAIL clamp_header: len=%0d required 96, hdr %h required %h", mon_q[0].u[15:0], mon_q[0].d, exp_q[0].d);
      end
      n_checks++;
      if (mon_q[1].d !== dat[DW-1:0] || mon_q[2].d !== dat[2*DW-1:DW] || !mon_q[2].l || mon_q[1].l) begin
        n_fail++; $display("FAIL clamp_payload: tlast %0b%0b required 01", mon_q[1].l, mon_q[2].l);
      end
    end
  endtask

  task automatic test_random();
    logic [2*DW-1:0] dat;
    logic [4:0] st;
    logic [7:0] rs, ix;
    logic [1:0] bt;
    int acc, waits;
    bit ok;
    for (int p = 0; p < 24; p++) begin
      dat = rand_data(); st = 5'($urandom); rs = 8'($urandom); ix = 8'($urandom); bt = 2'($urandom);
      mon_q.delete();
      model_pkt(st, rs, ix, bt, dat);
      send_req(st, rs, ix, bt, dat, 1'b0, acc, waits);
      collect(20, ok);
      n_checks++;
      if (!ok || mon_q.size() != exp_q.size()) begin
        n_fail++; $display("FAIL rand_len pkt %0d: got %0d beats required %0d", p, mon_q.size(), exp_q.size());
      end else begin
        foreach (exp_q[i]) begin
          n_checks++;
          if (mon_q[i].cyc != acc + exp_q[i].cyc || mon_q[i].d !== exp_q[i].d || mon_q[i].u !== exp_q[i].u ||
              mon_q[i].k !== exp_q[i].k || mon_q[i].l !== exp_q[i].l) begin
            n_fail++; $display("FAIL rand_beat pkt %0d beat %0d: cyc=%0d tlast=%0b data=%h required cyc=%0d tlast=%0b data=%h",
                               p, i, mon_q[i].cyc, mon_q[i].l, mon_q[i].d, acc + exp_q[i].cyc, exp_q[i].l, exp_q[i].d);
          end
        end
      end
      n_checks++;
      if (pkt_cnt !== m_cnt) begin n_fail++; $display("FAIL rand_cnt pkt %0d: got %0d required %0d", p, pkt_cnt, m_cnt); end
    end
  endtask

  task automatic test_back_to_back();
    logic [2*DW-1:0] da, db;
    logic [15:0] seq_a;
    int acc1, acc2, w1, w2;
    da = rand_data(); db = rand_data();
    seq_a = m_seq;
    mon_q.delete();
    send_req(5'd9, 8'h11, 8'h22, 2'd1, da, 1'b1, acc1, w1);
    send_req(5'd10, 8'h33, 8'h44, 2'd1, db, 1'b0, acc2, w2);
    repeat (4) begin @(posedge axis_clk); #1; end
    m_seq = m_seq + 16'd2; m_cnt = m_cnt + 32'd2;
    n_checks++;
    if (acc1 < 0 || acc2 < 0 || (acc2 - acc1) != 3 + IFG) begin
      n_fail++; $display("FAIL b2b_spacing: headers at %0d and %0d, required spacing %0d", acc1, acc2, 3 + IFG);
    end
    n_checks++;
    if (w2 != 2 + IFG) begin n_fail++; $display("FAIL b2b_ready_low: got %0d busy cycles required %0d", w2, 2 + IFG); end
    n_checks++;
    if (mon_q.size() != 4) begin
      n_fail++; $display("FAIL b2b_beats: got %0d required 4", mon_q.size());
    end else begin
      n_checks++;
      if (mon_q[2].cyc - mon_q[0].cyc != 3 + IFG || mon_q[0].d[143:128] !== seq_a ||
          mon_q[2].d[143:128] !== seq_a + 16'd1 || mon_q[2].d[119:112] !== 8'h33 || mon_q[3].d !== db[DW-1:0]) begin
        n_fail++; $display("FAIL b2b_headers: seq %0h/%0h required %0h/%0h", mon_q[0].d[143:128], mon_q[2].d[143:128], seq_a, seq_a + 16'd1);
      end
    end
    n_checks++;
    if (pkt_cnt !== m_cnt) begin n_fail++; $display("FAIL b2b_cnt: got %0d required %0d", pkt_cnt, m_cnt); end
  endtask

  task automatic test_reset_mid_packet();
    logic [2*DW-1:0] dat;
    int acc, waits, tl;
    bit ok;
    do_reset();
    dat = rand_data();
    send_req(5'd3, 8'd1, 8'd5, 2'd2, dat, 1'b0, acc, waits);
    @(posedge axis_clk); #1;
    areset = 1'b1;
    @(negedge axis_clk);
    n_checks++;
    if (tvalid !== 1'b1 || tlast !== 1'b0 || tdata !== dat[DW-1:0]) begin
      n_fail++; $display("FAIL midrst_pay0: tvalid=%0b tlast=%0b required 1 0", tvalid, tlast);
    end
    @(posedge axis_clk); #1;
    @(negedge axis_clk);
    n_checks++;
    if (tvalid !== 1'b0 || tlast !== 1'b0) begin n_fail++; $display("FAIL midrst_abort: tvalid=%0b tlast=%0b required 0 0", tvalid, tlast); end
    tl = 0;
    foreach (mon_q[i]) if (mon_q[i].l) tl++;
    n_checks++;
    if (tl != 0) begin n_fail++; $display("FAIL midrst_no_tlast: got %0d tlast beats required 0", tl); end
    n_checks++;
    if (pkt_cnt !== 32'd0) begin n_fail++; $display("FAIL midrst_cnt: got %0d required 0", pkt_cnt); end
    @(posedge axis_clk); #1;
    areset = 1'b0;
    mon_q.delete();
    model_pkt(5'd1, 8'd2, 8'd3, 2'd0, dat);
    send_req(5'd1, 8'd2, 8'd3, 2'd0, dat, 1'b0, acc, waits);
    collect(20, ok);
    n_checks++;
    if (!ok || mon_q.size() != 1 || mon_q[0].d !== exp_q[0].d || pkt_cnt !== 32'd1) begin
      n_fail++; $display("FAIL midrst_restart: beats=%0d cnt=%0d required 1 1 with seq 0", mon_q.size(), pkt_cnt);
    end
  endtask

  task automatic test_idle_zero();
    n_checks++;
    if (idle_bad != 0) begin n_fail++; $display("FAIL idle_outputs: got %0d nonzero idle cycles required 0", idle_bad); end
  endtask

  task automatic test_seq_wrap();
    bit done;
    logic [15:0] exp1, exp2;
    exp1 = 16'(65536 - 1);
    exp2 = 16'(65536);
    done = 1'b0;
    z_beats = 2'd0; z_valid = 1'b1;
    for (int t = 0; t < 140000 && !done; t++) begin
      @(posedge axis_clk); #1;
      if (z_n >= 65537) begin z_valid = 1'b0; done = 1'b1; end
    end
    repeat (3) begin @(posedge axis_clk); #1; end
    n_checks++;
    if (!done || z_n != 65537) begin n_fail++; $display("FAIL wrap_count: got %0d packets required 65537", z_n); end
    n_checks++;
    if (z_s1 !== exp1 || z_s2 !== exp2) begin
      n_fail++; $display("FAIL wrap_seq: got %0h then %0h required %0h then %0h", z_s1, z_s2, exp1, exp2);
    end
    n_checks++;
    if (z_bad != 0) begin n_fail++; $display("FAIL wrap_spacing: got %0d bad headers required 0", z_bad); end
    n_checks++;
    if (z_cnt !== 32'd65537) begin n_fail++; $display("FAIL wrap_pkt_cnt: got %0d required 65537", z_cnt); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    m_seq = '0; m_cnt = '0;
    areset = 1'b1; req_valid = 1'b0; req_stage_id = '0; req_resource_id = '0;
    req_index = '0; req_beats = '0; req_data = '0;
    z_areset = 1'b1; z_valid = 1'b0; z_stage = 5'd7; z_res = 8'd8; z_idx = 8'd9;
    z_beats = '0; z_data = '0;
    test_reset();
    test_basic();
    test_header_only();
    test_clamp();
    test_random();
    test_back_to_back();
    test_reset_mid_packet();
    test_idle_zero();
    test_seq_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_pkt_gen.md
CTRL_PKT_GEN -- requirements
Module: ctrl_pkt_gen

Interface
REQ-001 SHALL have parameter C_S_AXIS_DATA_WIDTH, default 256, giving the control-bus data width in bits.
REQ-002 SHALL have parameter C_S_AXIS_TUSER_WIDTH, default 128, giving the control-bus tuser width in bits.
REQ-003 SHALL have parameter IFG_CYCLES, default 2, giving the number of idle cycles forced after every packet.
REQ-004 SHALL have port axis_clk, input, 1 bit: the only clock.
REQ-005 SHALL have port areset, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port req_valid, input, 1 bit: a table-write request is present.
REQ-007 SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-008 SHALL have port req_stage_id, input, 5 bits: target stage ID.
REQ-009 SHALL have port req_resource_id, input, 8 bits: target table or resource inside the stage.
REQ-010 SHALL have port req_index, input, 8 bits: entry index.
REQ-011 SHALL have port req_beats, input, 2 bits: number of payload beats.
REQ-012 SHALL have port req_data, input, 2*C_S_AXIS_DATA_WIDTH bits: payload, beat 0 in the low half.
REQ-013 SHALL have port c_m_axis_tdata, output, C_S_AXIS_DATA_WIDTH bits: control data.
REQ-014 SHALL have port c_m_axis_tuser, output, C_S_AXIS_TUSER_WIDTH bits: metadata.
REQ-015 SHALL have port c_m_axis_tkeep, output, C_S_AXIS_DATA_WIDTH/8 bits: byte enables.
REQ-016 SHALL have port c_m_axis_tvalid, output, 1 bit: beat valid.
REQ-017 SHALL have port c_m_axis_tlast, output, 1 bit: last beat of the packet.
REQ-018 SHALL have port pkt_sent_cnt, output, 32 bits: count of completed packets.

Function
REQ-019 SHALL be the transmitter that feeds the stage control chain; the c_m_axis interface has no tready, so an accepted packet SHALL be emitted on consecutive cycles with no gaps.
REQ-020 SHALL implement the states IDLE, HDR, PAY0, PAY1 and GAP.
REQ-021 SHALL assert req_ready only in IDLE; a request is accepted when req_valid and req_ready are both high on a rising edge.
REQ-022 SHALL register all request fields when a request is accepted, so input changes afterwards have no effect.
REQ-023 SHALL emit the header beat on the cycle immediately after acceptance (latency 1).
REQ-024 Header-beat tdata SHALL be: [15:0]=16'hF1F2 magic, [108:104]=stage_id, [119:112]=resource_id, [127:120]=index, [143:128]=seq, and all other bits 0.
REQ-025 Header-beat tuser[15:0] SHALL be the packet length in bytes, (1+n)*C_S_AXIS_DATA_WIDTH/8, where n is the effective beat count; all other tuser bits SHALL be 0.
REQ-026 Payload beats SHALL carry tuser=0.
REQ-027 Every beat SHALL carry tkeep all ones.
REQ-028 Effective payload beat count n SHALL be req_beats, except that req_beats=3 SHALL be clamped to 2.
REQ-029 When n=0, the packet SHALL be header only, with tlast set on the header beat.
REQ-030 State transitions SHALL be: HDR goes to PAY0 if n≥1, else to GAP; PAY0 goes to PAY1 if n=2, else to GAP; PAY1 goes to GAP.
REQ-031 tlast SHALL be asserted only on the final beat of the packet.
REQ-032 GAP SHALL last exactly IFG_CYCLES cycles, then return to IDLE; with IFG_CYCLES=0, the state after the last beat SHALL be IDLE.
REQ-033 tvalid SHALL be 1 in HDR, PAY0 and PAY1; otherwise tvalid, tdata, tuser, tkeep and tlast SHALL all be 0.
REQ-034 seq SHALL be a 16-bit counter that increments once per packet on its tlast beat and wraps from 16'hFFFF to 0.
REQ-035 pkt_sent_cnt SHALL increment on each tlast beat and wrap modulo 2^32.
REQ-036 A request presented while the block is busy SHALL be held off by req_ready=0 and never dropped.

Reset
REQ-037 While areset is high, all outputs SHALL be 0, req_ready SHALL be 0, the state SHALL be IDLE, and seq and pkt_sent_cnt SHALL be 0.
REQ-038 req_ready SHALL go to 1 in the first cycle after areset is released.
REQ-039 A reset asserted mid-packet SHALL force tvalid=0 on the next cycle with no tlast issued, and the partial packet SHALL be abandoned without incrementing seq or pkt_sent_cnt.

Structure
REQ-040 The header field offsets, the magic value and the state encoding SHALL live in the shared package ctrl_pkt_pkg.
REQ-041 The block SHALL be a single module with no sub-modules.

Verification
REQ-042 Bench: request stage=3, res=1, idx=5, beats=2 → header at accept+1 with tuser[15:0]=96 and seq=0, then 2 payload beats with tlast on the second, then 2 idle cycles.
REQ-043 Bench: beats=0 → a single beat with tlast=1 and tuser[15:0]=32; pkt_sent_cnt becomes 1.
REQ-044 Bench: beats=3 → same output as beats=2, with tuser[15:0]=96.
REQ-045 Bench: back-to-back requests with req_valid held high → second header exactly 3+IFG_CYCLES cycles after the first header; req_ready=0 throughout.
REQ-046 Bench: preload seq to 16'hFFFF by sending 65535 packets, then send 2 more → the header seq fields read 16'hFFFF then 16'h0000.
REQ-047 Bench: areset asserted during PAY0 → tvalid=0 on the next cycle, no tlast, and pkt_sent_cnt unchanged.
